// File: rtl/strum_driver_if.sv
// Request handshake bundle for strum_driver: valid/ready plus the 3-bit line mask.
interface strum_driver_if;
  logic       req_valid;
  logic       req_ready;
  logic [2:0] req_mask;

  modport master (output req_valid, output req_mask, input req_ready);
  modport slave  (input req_valid, input req_mask, output req_ready);
endinterface

// File: rtl/strum_driver.sv
// Strum/foot press sequencer: queued masks become fixed-length presses separated by a released gap.
// Define STRUM_DRIVER_QUEUE_EN for a 4-entry request FIFO; otherwise a single holding register is used.
module strum_driver #(
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 3
) (
  input  logic           clk,
  input  logic           rst,
  strum_driver_if.slave  req,
  output logic [2:0]     inst,
  output logic           busy,
  output logic           evt_done
);

  typedef enum logic [1:0] {IDLE, PRESS, GAP} state_t;

  state_t      r_state;
  logic [15:0] r_timer;
  logic        r_started;

  logic        w_push;
  logic        w_pop;
  logic        w_empty;
  logic        w_room;
  logic [2:0]  w_head;

  assign req.req_ready = r_started & w_room;
  assign w_push        = req.req_valid & req.req_ready;
  assign w_pop         = (r_state == IDLE) & ~w_empty;
  assign busy          = (r_state != IDLE) | ~w_empty;

  // Holds req_ready low through reset and until the first clock edge after release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_started <= 1'b0;
    end else begin
      r_started <= 1'b1;
    end
  end

`ifdef STRUM_DRIVER_QUEUE_EN
  logic [2:0] r_mem [4];
  logic [1:0] r_wrPtr;
  logic [1:0] r_rdPtr;
  logic [2:0] r_occ;

  assign w_empty = (r_occ == 3'd0);
  assign w_room  = (r_occ < 3'd4);
  assign w_head  = r_mem[r_rdPtr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        r_mem[i] <= 3'b000;
      end
      r_wrPtr <= 2'd0;
      r_rdPtr <= 2'd0;
      r_occ   <= 3'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wrPtr] <= req.req_mask;
        r_wrPtr        <= r_wrPtr + 2'd1;
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + 2'd1;
      end
      case ({w_push, w_pop})
        2'b10:   r_occ <= r_occ + 3'd1;
        2'b01:   r_occ <= r_occ - 3'd1;
        default: r_occ <= r_occ;
      endcase
    end
  end
`else
  logic [2:0] r_hold;
  logic       r_holdValid;

  assign w_empty = ~r_holdValid;
  assign w_room  = (r_state == IDLE) & ~r_holdValid;
  assign w_head  = r_hold;

  // Push and pop are mutually exclusive here: push needs an empty holder, pop a full one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hold      <= 3'b000;
      r_holdValid <= 1'b0;
    end else if (w_push) begin
      r_hold      <= req.req_mask;
      r_holdValid <= 1'b1;
    end else if (w_pop) begin
      r_holdValid <= 1'b0;
    end
  end
`endif

  // An all-zero mask is popped and dropped without leaving IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_timer  <= 16'd0;
      inst     <= 3'b000;
      evt_done <= 1'b0;
    end else begin
      evt_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_pop && (w_head != 3'b000)) begin
            inst    <= w_head;
            r_timer <= 16'(HOLD_CYCLES - 1);
            r_state <= PRESS;
          end
        end
        PRESS: begin
          if (r_timer == 16'd0) begin
            inst    <= 3'b000;
            r_timer <= 16'(GAP_CYCLES - 1);
            r_state <= GAP;
          end else begin
            r_timer <= r_timer - 16'd1;
          end
        end
        GAP: begin
          if (r_timer == 16'd0) begin
            evt_done <= 1'b1;
            r_state  <= IDLE;
          end else begin
            r_timer <= r_timer - 16'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_strum_driver.sv
// Scoreboard bench for strum_driver: accepted masks are queued as expected presses,
// and a monitor pops them as presses appear on inst, checking hold, gap and evt_done timing.
module tb_strum_driver;
  localparam int HOLD = 4;
  localparam int GAP  = 3;

  logic       clk;
  logic       rst;
  logic [2:0] inst;
  logic       busy;
  logic       evtDone;

  strum_driver_if reqIf();

  strum_driver #(.HOLD_CYCLES(HOLD), .GAP_CYCLES(GAP)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (reqIf),
    .inst     (inst),
    .busy     (busy),
    .evt_done (evtDone)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         testsRun    = 0;
  int         testsFailed = 0;
  logic [2:0] expQ[$];
  int         expDone = 0;
  int         gotDone = 0;

  bit         pressOn    = 0;
  bit         gapPending = 0;
  bit         seenPress  = 0;
  int         holdLen    = 0;
  int         lowLen     = 0;
  logic [2:0] curMask    = 3'b000;

  task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Offers one mask and waits (bounded) for the handshake; returns the number of refused cycles.
  task automatic applyStimulus(input logic [2:0] mask, output int waited);
    bit accepted;
    accepted = 0;
    waited   = 0;
    reqIf.req_valid = 1'b1;
    reqIf.req_mask  = mask;
    while (!accepted && waited < 200) begin
      if (reqIf.req_ready === 1'b1) begin
        accepted = 1;
        if (mask != 3'b000) begin
          expQ.push_back(mask);
          expDone++;
        end
      end else begin
        waited++;
      end
      @(negedge clk);
    end
    reqIf.req_valid = 1'b0;
    reqIf.req_mask  = 3'b000;
    if (!accepted) checkOutput("accept_timeout", 16'd0, 16'd1);
  endtask

  task automatic waitIdle();
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (busy !== 1'b0) checkOutput("drain_timeout", 16'(busy), 16'd0);
    repeat (2) @(negedge clk);
  endtask

  task automatic resetMidPress();
    rst = 1'b1;
    #1;
    checkOutput("async_inst", 16'(inst), 16'd0);
    checkOutput("async_busy", 16'(busy), 16'd0);
    checkOutput("async_evt", 16'(evtDone), 16'd0);
    expQ.delete();
    expDone = gotDone;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("ready_held_low", 16'(reqIf.req_ready), 16'd0);
    @(negedge clk);
    checkOutput("post_rst_busy", 16'(busy), 16'd0);
    checkOutput("post_rst_ready", 16'(reqIf.req_ready), 16'd1);
    repeat (10) begin
      @(negedge clk);
      checkOutput("no_press_after_rst", 16'(inst), 16'd0);
    end
  endtask

  // Monitor: each 0->nonzero edge on inst is one press to match against the queue head.
  always @(negedge clk) begin
    if (rst) begin
      pressOn    = 0;
      gapPending = 0;
      seenPress  = 0;
      holdLen    = 0;
      lowLen     = 0;
    end else begin
      if (inst != 3'b000) begin
        if (!pressOn) begin
          if (seenPress) checkOutput("gap_min", 16'(lowLen >= GAP), 16'd1);
          if (expQ.size() == 0) begin
            checkOutput("unexpected_press", 16'(inst), 16'd0);
          end else begin
            checkOutput("press_mask", 16'(inst), 16'(expQ.pop_front()));
          end
          curMask = inst;
          pressOn = 1;
          holdLen = 1;
        end else begin
          if (inst != curMask) checkOutput("press_stable", 16'(inst), 16'(curMask));
          holdLen++;
        end
        lowLen = 0;
      end else begin
        if (pressOn) begin
          checkOutput("hold_len", 16'(holdLen), 16'(HOLD));
          pressOn    = 0;
          gapPending = 1;
          seenPress  = 1;
          lowLen     = 0;
        end
        lowLen++;
      end
      if (gapPending && lowLen == GAP + 1) begin
        checkOutput("evt_done", 16'(evtDone), 16'd1);
        gapPending = 0;
        if (evtDone) gotDone++;
      end else if (evtDone) begin
        checkOutput("evt_spurious", 16'd1, 16'd0);
        gotDone++;
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int         w;
    logic [2:0] m;
    int         nIdle;

    rst = 1'b1;
    reqIf.req_valid = 1'b0;
    reqIf.req_mask  = 3'b000;
    repeat (2) @(negedge clk);
    checkOutput("rst_inst", 16'(inst), 16'd0);
    checkOutput("rst_ready", 16'(reqIf.req_ready), 16'd0);
    checkOutput("rst_busy", 16'(busy), 16'd0);
    checkOutput("rst_evt", 16'(evtDone), 16'd0);
    rst = 1'b0;
    #1;
    checkOutput("ready_before_edge", 16'(reqIf.req_ready), 16'd0);
    @(negedge clk);
    checkOutput("ready_after_edge", 16'(reqIf.req_ready), 16'd1);

    $display("[TB] single press latency");
    applyStimulus(3'b001, w);
    checkOutput("lat_edge1", 16'(inst), 16'd0);
    @(negedge clk);
    checkOutput("lat_edge2", 16'(inst), 16'd1);
    waitIdle();

    $display("[TB] zero mask");
    applyStimulus(3'b000, w);
    @(negedge clk);
    checkOutput("zero_busy", 16'(busy), 16'd0);
    repeat (6) begin
      @(negedge clk);
      checkOutput("zero_inst", 16'(inst), 16'd0);
    end

`ifdef STRUM_DRIVER_QUEUE_EN
    $display("[TB] back-to-back queued");
    applyStimulus(3'b001, w);
    applyStimulus(3'b010, w);
    checkOutput("b2b_wait2", 16'(w), 16'd0);
    applyStimulus(3'b100, w);
    checkOutput("b2b_wait3", 16'(w), 16'd0);
    waitIdle();

    $display("[TB] queue full");
    applyStimulus(3'b001, w);
    @(negedge clk);
    checkOutput("press_active", 16'(inst), 16'd1);
    applyStimulus(3'b011, w);
    checkOutput("fill_wait", 16'(w), 16'd0);
    applyStimulus(3'b101, w);
    checkOutput("fill_wait", 16'(w), 16'd0);
    applyStimulus(3'b110, w);
    checkOutput("fill_wait", 16'(w), 16'd0);
    applyStimulus(3'b111, w);
    checkOutput("fill_wait", 16'(w), 16'd0);
    checkOutput("full_ready", 16'(reqIf.req_ready), 16'd0);
    applyStimulus(3'b010, w);
    checkOutput("fifth_waited", 16'(w > 0), 16'd1);
    waitIdle();

    $display("[TB] reset mid-press with queued requests");
    applyStimulus(3'b001, w);
    applyStimulus(3'b010, w);
    applyStimulus(3'b100, w);
    resetMidPress();
`else
    $display("[TB] holding register back-to-back");
    applyStimulus(3'b001, w);
    checkOutput("hold_ready_low", 16'(reqIf.req_ready), 16'd0);
    applyStimulus(3'b110, w);
    checkOutput("hold_wait", 16'(w), 16'(HOLD + GAP + 1));
    waitIdle();

    $display("[TB] reset mid-press");
    applyStimulus(3'b101, w);
    @(negedge clk);
    resetMidPress();
`endif

    $display("[TB] random traffic");
    for (int i = 0; i < 24; i++) begin
      m = ($urandom_range(0, 5) == 0) ? 3'b000 : 3'($urandom_range(1, 7));
      applyStimulus(m, w);
      nIdle = $urandom_range(0, 2);
      repeat (nIdle) @(negedge clk);
    end
    waitIdle();
    checkOutput("queue_drained", 16'(expQ.size()), 16'd0);
    checkOutput("done_count", 16'(gotDone), 16'(expDone));

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/strum_driver.md
STRUM_DRIVER -- requirements
Module: strum_driver

Interface
REQ-001 SHALL have parameter HOLD_CYCLES, default 4, the number of cycles each press holds inst high (legal 1..65535).
REQ-002 SHALL have parameter GAP_CYCLES, default 3, the minimum number of released cycles between presses (legal 1..65535).
REQ-003 SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port req_valid, input, 1 bit: a press request is offered.
REQ-006 SHALL have port req_ready, output, 1 bit: the block can accept a request this cycle.
REQ-007 SHALL have port req_mask, input, 3 bits: the lines to press. Bit0 = green strum, bit1 = blue strum, bit2 = drum foot.
REQ-008 SHALL have port inst, output, 3 bits: registered instrument lines driven to the strum/foot debounce receiver, same bit order as req_mask.
REQ-009 SHALL have port busy, output, 1 bit: high when the FSM is not IDLE or the queue is non-empty.
REQ-010 SHALL have port evt_done, output, 1 bit: one-cycle pulse at the end of each GAP phase.

Function
REQ-011 SHALL accept a request on a rising edge where req_valid and req_ready are both high; req_mask is captured at that edge.
REQ-012 SHALL implement an FSM with states IDLE, PRESS and GAP.
REQ-013 IDLE: when a pending request exists, SHALL pop it, set inst to its mask, load the counter with HOLD_CYCLES-1 and go to PRESS.
REQ-014 PRESS: SHALL decrement the counter each cycle; when the counter is 0, SHALL set inst to 0, load GAP_CYCLES-1 and go to GAP.
REQ-015 GAP: SHALL decrement the counter each cycle; when the counter is 0, SHALL pulse evt_done for 1 cycle and go to IDLE.
REQ-016 inst SHALL be non-zero for exactly HOLD_CYCLES consecutive cycles per press, then zero for at least GAP_CYCLES cycles.
REQ-017 Latency: with an empty queue and the FSM in IDLE, inst SHALL change 2 rising edges after the accepting edge (1 for the queue write, 1 for the pop).
REQ-018 A request with req_mask == 0 SHALL be accepted and discarded at the pop: no PRESS phase, no evt_done, FSM stays in IDLE.
REQ-019 inst SHALL change only on a transition into PRESS or GAP, never mid-phase.
REQ-020 A new request SHALL never alter an in-progress press.
REQ-021 The counter SHALL be 16 bits and SHALL not wrap within a phase.
REQ-022 A simultaneous pop and push in the same cycle SHALL be legal and SHALL keep the occupancy unchanged.
REQ-023 Requests SHALL be served in strict FIFO order.

Reset
REQ-024 While rst is high: inst = 0, req_ready = 0, busy = 0, evt_done = 0, FSM = IDLE, counter = 0, queue empty.
REQ-025 Assertion of rst mid-PRESS SHALL force inst to 0 immediately without waiting for clk, and SHALL discard all pending requests.
REQ-026 req_ready SHALL go high on the first rising edge after rst deasserts.

Configuration
REQ-027 Macro STRUM_DRIVER_QUEUE_EN defined: a 4-entry request FIFO SHALL be built; req_ready = (occupancy < 4).
REQ-028 Macro STRUM_DRIVER_QUEUE_EN undefined: a single holding register SHALL be built; req_ready = (FSM == IDLE and holding register empty). All other behaviour SHALL be identical.

Verification (HOLD_CYCLES=4, GAP_CYCLES=3)
REQ-029 Request mask=3'b001 with the block idle -> inst=001 for exactly 4 cycles starting 2 edges after acceptance, then 000 for 3 cycles, then evt_done pulses once.
REQ-030 Back-to-back requests 001, 010, 100 (queue enabled) -> all 3 accepted on consecutive edges; presses in that order; each press 4 cycles high; at least 3 low cycles between presses; 3 evt_done pulses.
REQ-031 Queue enabled, 5 requests offered while PRESS is active -> req_ready low after 4 are queued; the 5th is accepted only after the first pop.
REQ-032 Request mask=000 -> accepted, inst stays 000, no evt_done, busy low within 2 cycles.
REQ-033 rst pulsed during cycle 2 of a PRESS with 2 requests queued -> inst=000 asynchronously; no further presses; busy=0 after reset releases.
REQ-034 Queue disabled, requests 001 and 110 offered back-to-back -> req_ready low from acceptance of 001 until the FSM returns to IDLE; 110 is pressed after 001's GAP.
